fd_fetch_buffer: RTL and testbench

//  Small FIFO of fetched instructions that sits between the F-stage PC/IM and the D stage.

---
 rtl/fd_fetch_buffer.sv | 77 +++++++
 tb/tb_fd_fetch_buffer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fd_fetch_buffer.sv
// F->D instruction fetch buffer: a small FIFO of {pc, instr, excode} that decouples
// D-stage holds from the fetch path and tags AdEL fetch faults before decode.
module fd_fetch_buffer #(
    parameter int          DEPTH  = 2,
    parameter logic [31:0] PC_MIN = 32'h0000_3000,
    parameter logic [31:0] PC_MAX = 32'h0000_6FFC
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  F_pc,
    input  logic [31:0]                  F_instr,
    input  logic                         F_valid,
    output logic                         F_stall,
    input  logic                         D_stall,
    input  logic                         flush,
    output logic                         D_valid,
    output logic [31:0]                  D_pc,
    output logic [31:0]                  D_instr,
    output logic [4:0]                   D_excode,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [4:0]    EX_ADEL = 5'd4;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic [4:0]  ex_mem    [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          enq;
    logic          deq;
    logic          fault;

    assign F_stall = (count == FULL);
    assign D_valid = (count != '0);
    assign enq     = F_valid & ~F_stall & ~flush;
    assign deq     = D_valid & ~D_stall & ~flush;
    assign fault   = (F_pc[1:0] != 2'b00) | (F_pc < PC_MIN) | (F_pc > PC_MAX);

    assign D_pc     = D_valid ? pc_mem[rd_ptr]    : 32'h0;
    assign D_instr  = D_valid ? instr_mem[rd_ptr] : 32'h0;
    assign D_excode = D_valid ? ex_mem[rd_ptr]    : 5'd0;

    // Faulting fetches become a nop carrying AdEL so decode never sees a bogus word.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr]    <= F_pc;
            instr_mem[wr_ptr] <= fault ? 32'h0 : F_instr;
            ex_mem[wr_ptr]    <= fault ? EX_ADEL : 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fd_fetch_buffer.sv
// Bench for fd_fetch_buffer: directed scenarios then random traffic, every cycle
// compared against a queue model of the fetch buffer.
module tb_fd_fetch_buffer;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic [31:0] F_pc;
    logic [31:0] F_instr;
    logic        F_valid;
    logic        F_stall;
    logic        D_stall;
    logic        flush;
    logic        D_valid;
    logic [31:0] D_pc;
    logic [31:0] D_instr;
    logic [4:0]  D_excode;
    logic [1:0]  count;

    int errors = 0;
    int checks = 0;

    // Model entries packed as {pc[31:0], instr[31:0], excode[4:0]}.
    logic [68:0] exp_q[$];

    fd_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .F_pc(F_pc), .F_instr(F_instr), .F_valid(F_valid),
        .F_stall(F_stall), .D_stall(D_stall), .flush(flush), .D_valid(D_valid),
        .D_pc(D_pc), .D_instr(D_instr), .D_excode(D_excode), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_fault(input logic [31:0] pc);
        return ((pc % 4) != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
    endfunction

    // Apply one clock of the buffer's rules to the model, using the inputs of this cycle.
    task automatic model_update();
        int  n;
        bit  do_enq;
        bit  do_deq;
        n = exp_q.size();
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            do_enq = F_valid && (n < DEPTH);
            do_deq = (n > 0) && !D_stall;
            if (do_deq) void'(exp_q.pop_front());
            if (do_enq) begin
                if (is_fault(F_pc)) exp_q.push_back({F_pc, 32'h0, 5'd4});
                else                exp_q.push_back({F_pc, F_instr, 5'd0});
            end
        end
    endtask

    task automatic compare_all();
        logic [68:0] head;
        int          n;
        n    = exp_q.size();
        head = (n > 0) ? exp_q[0] : 69'h0;
        chk("count",    32'(count),    32'(n));
        chk("D_valid",  32'(D_valid),  32'(n != 0));
        chk("F_stall",  32'(F_stall),  32'(n == DEPTH));
        chk("D_pc",     D_pc,          head[68:37]);
        chk("D_instr",  D_instr,       head[36:5]);
        chk("D_excode", 32'(D_excode), 32'(head[4:0]));
        chk("count_le_depth", 32'(count <= 2'(DEPTH)), 32'd1);
    endtask

    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ds, input logic fl, input logic r);
        F_valid = v;
        F_pc    = pc;
        F_instr = ins;
        D_stall = ds;
        flush   = fl;
        rst     = r;
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    function automatic logic [31:0] rand_pc();
        case ($urandom_range(0, 3))
            0, 1:    return 32'h3000 + ($urandom_range(0, 4095) << 2);
            2:       return (32'h3000 + ($urandom_range(0, 4095) << 2)) | 32'($urandom_range(1, 3));
            default: begin
                case ($urandom_range(0, 2))
                    0:       return 32'h2FFC;
                    1:       return 32'h7000;
                    default: return $urandom();
                endcase
            end
        endcase
    endfunction

    initial begin
        logic [31:0] pc;
        F_valid = 1'b0; F_pc = 32'h0; F_instr = 32'h0;
        D_stall = 1'b0; flush = 1'b0; rst = 1'b1;

        // Reset held two cycles with fetch offered.
        step(1, 32'h3000, 32'hAAAA_0000, 0, 0, 1);
        step(1, 32'h3000, 32'hAAAA_0000, 0, 0, 1);
        chk("rst_count",   32'(count),   32'd0);
        chk("rst_D_valid", 32'(D_valid), 32'd0);
        chk("rst_D_instr", D_instr,      32'h0);
        chk("rst_F_stall", 32'(F_stall), 32'd0);

        // Streaming with no hold: one-cycle latency, occupancy stays at one.
        for (int i = 0; i < 4; i++) begin
            step(1, 32'h3000 + 32'(4 * i), 32'h1000_0000 + 32'(i), 0, 0, 0);
            chk("stream_pc",    D_pc,        32'h3000 + 32'(4 * i));
            chk("stream_count", 32'(count),  32'd1);
        end
        step(0, 32'h0, 32'h0, 0, 0, 0);
        chk("drain_count", 32'(count), 32'd0);

        // Hold D while fetching: fill to full, third word refused.
        step(1, 32'h3000, 32'h2000_0000, 1, 0, 0);
        chk("hold_c1", 32'(count), 32'd1);
        step(1, 32'h3004, 32'h2000_0001, 1, 0, 0);
        chk("hold_c2", 32'(count), 32'd2);
        chk("hold_fs", 32'(F_stall), 32'd1);
        step(1, 32'h3008, 32'h2000_0002, 1, 0, 0);
        chk("hold_c3", 32'(count), 32'd2);
        chk("hold_head", D_pc, 32'h3000);
        step(1, 32'h3008, 32'h2000_0002, 0, 0, 0);
        chk("release_pc", D_pc, 32'h3004);
        chk("release_fs", 32'(F_stall), 32'd0);
        // count==1 with enq and deq together.
        step(1, 32'h3008, 32'h2000_0002, 0, 0, 0);
        chk("enqdeq_pc",    D_pc,       32'h3008);
        chk("enqdeq_count", 32'(count), 32'd1);
        chk("enqdeq_instr", D_instr,    32'h2000_0002);
        step(0, 32'h0, 32'h0, 0, 0, 0);

        // Flush when full with a fetch offered.
        step(1, 32'h3100, 32'h3000_0000, 1, 0, 0);
        step(1, 32'h3104, 32'h3000_0001, 1, 0, 0);
        step(1, 32'h3108, 32'h3000_0002, 0, 1, 0);
        chk("flush_count", 32'(count),   32'd0);
        chk("flush_valid", 32'(D_valid), 32'd0);
        chk("flush_fs",    32'(F_stall), 32'd0);
        step(0, 32'h0, 32'h0, 0, 0, 0);
        chk("flush_nostore", 32'(count), 32'd0);

        // Fetch address faults, then the top legal address.
        step(1, 32'h3002, 32'hDEAD_BEEF, 0, 0, 0);
        chk("misalign_ex", 32'(D_excode), 32'd4);
        chk("misalign_in", D_instr,       32'h0);
        chk("misalign_pc", D_pc,          32'h3002);
        step(1, 32'h2FFC, 32'hDEAD_BEEF, 0, 0, 0);
        chk("low_ex", 32'(D_excode), 32'd4);
        chk("low_in", D_instr,       32'h0);
        step(1, 32'h7000, 32'hDEAD_BEEF, 0, 0, 0);
        chk("high_ex", 32'(D_excode), 32'd4);
        chk("high_in", D_instr,       32'h0);
        step(1, 32'h6FFC, 32'hCAFE_F00D, 0, 0, 0);
        chk("top_ex", 32'(D_excode), 32'd0);
        chk("top_in", D_instr,       32'hCAFE_F00D);
        step(0, 32'h0, 32'h0, 0, 0, 0);

        // Reset mid-operation overrides a pending enqueue.
        step(1, 32'h3200, 32'h4000_0000, 1, 0, 0);
        step(1, 32'h3204, 32'h4000_0001, 1, 0, 0);
        step(1, 32'h3208, 32'h4000_0002, 0, 1, 1);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_pc",    D_pc,       32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            pc = rand_pc();
            step(1'($urandom_range(0, 3) != 0), pc, $urandom(),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 49) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
